// File: rtl/skew_feeder.sv
// ---------------------------------------------------------------------------
// skew_feeder
//
// Lane-skew feeder for the edge of a systolic array. It takes one LEN-lane
// vector per accepted beat and delays lane i by a multiple of STEP beats:
//   SKEW   (mode = 0): delay STEP*i          -> builds the diagonal wavefront
//   DESKEW (mode = 1): delay STEP*(LEN-1-i)  -> realigns a wavefront leaving
// After the last beat of a frame the feeder drains itself by shifting zeros
// for D = STEP*(LEN-1) cycles. It flags the final output beat with out_last.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   mode       in   0 = SKEW, 1 = DESKEW, sampled on the first beat of a frame
//   in_valid   in   input beat present
//   in_ready   out  beat accepted when in_valid && in_ready (low while draining)
//   in_last    in   accepted beat is the last of its frame
//   x_in       in   LEN lanes of DEP-bit signed data, lane i = x_in[i]
//   out_valid  out  x_out holds a valid beat
//   out_last   out  final beat of the output frame (qualified by out_valid)
//   x_out      out  LEN lanes of DEP-bit signed data, lane i = x_out[i]
//   busy       out  feeder is inside a frame (RUN or DRAIN)
// ---------------------------------------------------------------------------
module skew_feeder #(
    parameter int DEP  = 8,
    parameter int LEN  = 4,
    parameter int STEP = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mode,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic signed [LEN-1:0][DEP-1:0] x_in,
    output logic                           out_valid,
    output logic                           out_last,
    output logic signed [LEN-1:0][DEP-1:0] x_out,
    output logic                           busy
);

    // Drain length in beats and the width of the drain counter.
    localparam int D  = STEP * (LEN - 1);
    localparam int CW = (D > 0) ? $clog2(D + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] drain_cnt_q, drain_cnt_d;
    logic          mode_q, mode_d;

    logic          acc;        // input beat accepted this cycle
    logic          adv;        // chains advance this cycle
    logic          drain;      // DRAIN state
    logic          final_adv;  // this advance produces the frame's last beat
    logic          eff_mode;   // mode in force for this cycle's tap selection

    logic [DEP-1:0] lane_in [LEN];
    logic [DEP-1:0] tap     [LEN];

    assign drain    = (state_q == S_DRAIN);
    assign in_ready = !drain;
    assign busy     = (state_q != S_IDLE);
    assign acc      = in_valid && in_ready;
    assign adv      = acc || drain;

    // The first beat of a frame already follows the incoming mode; from then
    // on the latched copy is used so mid-frame toggles have no effect.
    assign eff_mode = (state_q == S_IDLE) ? mode : mode_q;

    // Final advance: last drain step, or the in_last beat itself when there
    // is nothing to drain (single lane).
    assign final_adv = (drain && (drain_cnt_q == CW'(1)))
                    || (acc && in_last && (D == 0));

    // Zeros are pushed into every lane while draining.
    always_comb begin
        for (int i = 0; i < LEN; i++) begin
            lane_in[i] = drain ? '0 : x_in[i];
        end
    end

    // ---------------------------------------------------------------------
    // Frame control FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        mode_d      = mode_q;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    mode_d = mode;
                    if (in_last) begin
                        if (D > 0) begin
                            state_d     = S_DRAIN;
                            drain_cnt_d = CW'(D);
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (acc && in_last) begin
                    if (D > 0) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = CW'(D);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q - CW'(1);
                if (drain_cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                drain_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            mode_q      <= mode_d;
        end
    end

    // ---------------------------------------------------------------------
    // Per-lane delay chains: every lane owns a full D-deep chain and the
    // mode only moves the tap, so switching modes never needs a re-size.
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < LEN; i++) begin : g_lane
        localparam int DS = STEP * i;
        localparam int DD = STEP * (LEN - 1 - i);

        logic [DEP-1:0] tap_s, tap_d;

        if (D > 0) begin : g_chain
            logic [DEP-1:0] chain_q [D];

            // Chain holds on stall cycles, so positions count advances only.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) begin
                        chain_q[k] <= '0;
                    end
                end else if (adv) begin
                    chain_q[0] <= lane_in[i];
                    for (int k = 1; k < D; k++) begin
                        chain_q[k] <= chain_q[k-1];
                    end
                end
            end

            // A zero-depth lane bypasses its chain entirely.
            if (DS == 0) begin : g_s_thru
                assign tap_s = lane_in[i];
            end else begin : g_s_tap
                assign tap_s = chain_q[DS-1];
            end

            if (DD == 0) begin : g_d_thru
                assign tap_d = lane_in[i];
            end else begin : g_d_tap
                assign tap_d = chain_q[DD-1];
            end
        end else begin : g_thru
            assign tap_s = lane_in[i];
            assign tap_d = lane_in[i];
        end

        assign tap[i] = eff_mode ? tap_d : tap_s;
    end

    // ---------------------------------------------------------------------
    // Output register: carries a beat only on advance cycles, zero otherwise
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            x_out     <= '0;
        end else if (adv) begin
            out_valid <= 1'b1;
            out_last  <= final_adv;
            for (int i = 0; i < LEN; i++) begin
                x_out[i] <= tap[i];
            end
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            x_out     <= '0;
        end
    end

endmodule

// File: tb/tb_skew_feeder.sv
module tb_skew_feeder;

    localparam int LENS  [3] = '{4, 3, 1};
    localparam int STEPS [3] = '{1, 2, 1};

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // DUT0: LEN=4 STEP=1, DUT1: LEN=3 STEP=2, DUT2: LEN=1 STEP=1
    logic iv0, il0, md0, rdy0, ov0, ol0, bz0;
    logic iv1, il1, md1, rdy1, ov1, ol1, bz1;
    logic iv2, il2, md2, rdy2, ov2, ol2, bz2;
    logic signed [3:0][7:0] x0, xo0;
    logic signed [2:0][7:0] x1, xo1;
    logic signed [0:0][7:0] x2, xo2;

    exp_t q0[$], q1[$], q2[$];
    logic [31:0] hist[$];
    logic fmode;
    logic in_frame;
    logic cont;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    skew_feeder #(.DEP(8), .LEN(4), .STEP(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mode(md0), .in_valid(iv0), .in_ready(rdy0),
        .in_last(il0), .x_in(x0), .out_valid(ov0), .out_last(ol0), .x_out(xo0),
        .busy(bz0));

    skew_feeder #(.DEP(8), .LEN(3), .STEP(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mode(md1), .in_valid(iv1), .in_ready(rdy1),
        .in_last(il1), .x_in(x1), .out_valid(ov1), .out_last(ol1), .x_out(xo1),
        .busy(bz1));

    skew_feeder #(.DEP(8), .LEN(1), .STEP(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .mode(md2), .in_valid(iv2), .in_ready(rdy2),
        .in_last(il2), .x_in(x2), .out_valid(ov2), .out_last(ol2), .x_out(xo2),
        .busy(bz2));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int k, input logic [31:0] d, input logic l);
        exp_t e;
        e.d    = d;
        e.last = l;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic rdy_of(input int k);
        case (k)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    // Reference: output beat j, lane i carries input beat j-d (zero if none).
    function automatic logic [31:0] exp_beat(input int k, input int j);
        logic [31:0] r;
        logic [31:0] h;
        int d;
        r = '0;
        for (int i = 0; i < LENS[k]; i++) begin
            d = fmode ? STEPS[k] * (LENS[k] - 1 - i) : STEPS[k] * i;
            if (j - d >= 0) begin
                h = hist[j-d];
                r[i*8 +: 8] = h[i*8 +: 8];
            end
        end
        return r;
    endfunction

    task automatic set_in(input int k, input logic v, input logic [31:0] d,
                          input logic l, input logic m);
        case (k)
            0: begin iv0 = v; x0 = d;        il0 = l; md0 = m; end
            1: begin iv1 = v; x1 = d[23:0];  il1 = l; md1 = m; end
            default: begin iv2 = v; x2 = d[7:0]; il2 = l; md2 = m; end
        endcase
    endtask

    // Present one beat, wait (bounded) for acceptance, push expectations.
    task automatic drive_beat(input int k, input logic [31:0] v, input logic last,
                              input logic m);
        logic acc;
        int dk;
        acc = 1'b0;
        dk  = STEPS[k] * (LENS[k] - 1);
        if (!in_frame) begin
            hist.delete();
            fmode    = m;
            in_frame = 1'b1;
        end
        set_in(k, 1'b1, v, last, m);
        for (int t = 0; t < 40 && !acc; t++) begin
            acc = rdy_of(k);
            @(posedge clk);
            #1;
        end
        set_in(k, 1'b0, v, 1'b0, m);
        if (!acc) begin
            chk("accept_timeout", 64'd0, 64'd1);
            return;
        end
        hist.push_back(v);
        push_exp(k, exp_beat(k, hist.size() - 1), last && (dk == 0));
        if (last) begin
            for (int c = 0; c < dk; c++) begin
                hist.push_back('0);
                push_exp(k, exp_beat(k, hist.size() - 1), c == dk - 1);
            end
            in_frame = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 60 && (q0.size() + q1.size() + q2.size()) != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_done", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        idle_cycles(2);
    endtask

    task automatic mon(input int k, input logic ov, input logic ol, input logic [31:0] xo);
        exp_t e;
        if (!ov) begin
            chk($sformatf("dut%0d_idle_zero", k), {31'b0, ol, xo}, 64'd0);
        end else if (qsize(k) == 0) begin
            chk($sformatf("dut%0d_unexpected_beat", k), 64'd1, 64'd0);
        end else begin
            case (k)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("dut%0d_data", k), {32'b0, xo}, {32'b0, e.d});
            chk($sformatf("dut%0d_last", k), {63'b0, ol}, {63'b0, e.last});
        end
    endtask

    always @(negedge clk) if (rst_n) mon(0, ov0, ol0, xo0);
    always @(negedge clk) if (rst_n) mon(1, ov1, ol1, {8'h00, xo1});
    always @(negedge clk) if (rst_n) mon(2, ov2, ol2, {24'h0, xo2});
    always @(negedge clk) if (rst_n && cont) chk("b2b_contiguous", {63'b0, ov0}, 64'd1);

    initial begin
        logic [31:0] v;
        int n;
        logic m;
        iv0 = 0; il0 = 0; md0 = 0; x0 = '0;
        iv1 = 0; il1 = 0; md1 = 0; x1 = '0;
        iv2 = 0; il2 = 0; md2 = 0; x2 = '0;
        fmode = 0; in_frame = 0; cont = 0;

        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_ready", {63'b0, rdy0}, 64'd1);
        chk("rst_busy",  {63'b0, bz0},  64'd0);
        chk("rst_outs",  {30'b0, ov0, ol0, xo0}, 64'd0);

        // SKEW, LEN=4 STEP=1
        drive_beat(0, 32'h0D0C0B0A, 1'b0, 1'b0);
        drive_beat(0, 32'h17161514, 1'b1, 1'b0);
        chk("skew_busy_drain", {63'b0, bz0}, 64'd1);
        for (int c = 0; c < 3; c++) begin
            chk("skew_ready_low", {63'b0, rdy0}, 64'd0);
            idle_cycles(1);
        end
        chk("skew_ready_back", {63'b0, rdy0}, 64'd1);
        chk("skew_last_with_ready", {63'b0, ol0}, 64'd1);
        wait_drain();

        // DESKEW, mode toggled on the second beat (must be ignored)
        drive_beat(0, 32'h0D0C0B0A, 1'b0, 1'b1);
        drive_beat(0, 32'h17161514, 1'b1, 1'b0);
        wait_drain();

        // Stall: 2-cycle input gap after beat 1
        drive_beat(0, 32'h80FF7F01, 1'b0, 1'b0);
        drive_beat(0, 32'h04030201, 1'b0, 1'b0);
        for (int g = 0; g < 2; g++) begin
            @(posedge clk);
            #1;
            chk("stall_gap", {30'b0, ov0, ol0, xo0}, 64'd0);
        end
        drive_beat(0, 32'h0C0B0A09, 1'b1, 1'b0);
        wait_drain();

        // STEP=2, LEN=3: single beat {-1, 5, -128}
        drive_beat(1, 32'h008005FF, 1'b1, 1'b0);
        wait_drain();

        // Back-to-back: second frame accepted in the out_last cycle
        drive_beat(0, 32'h44332211, 1'b0, 1'b0);
        cont = 1'b1;
        drive_beat(0, 32'h88776655, 1'b1, 1'b0);
        drive_beat(0, 32'hCCBBAA99, 1'b0, 1'b1);
        drive_beat(0, 32'h01F0E0D0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        cont = 1'b0;
        wait_drain();

        // LEN=1: no drain, out_last on the in_last beat, ready stays high
        drive_beat(2, 32'h0000007F, 1'b0, 1'b0);
        drive_beat(2, 32'h00000080, 1'b0, 1'b1);
        drive_beat(2, 32'h000000A5, 1'b1, 1'b0);
        chk("len1_ready_high", {63'b0, rdy2}, 64'd1);
        chk("len1_not_busy",   {63'b0, bz2},  64'd0);
        chk("len1_last_now",   {63'b0, ol2},  64'd1);
        wait_drain();

        // Randomised frames with gaps and ignored mode toggles
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 4);
            m = 1'($urandom_range(0, 1));
            for (int b = 0; b < n; b++) begin
                v = $urandom;
                drive_beat(r % 2, v, b == n - 1, (b == 0) ? m : 1'($urandom_range(0, 1)));
                if (b != n - 1) idle_cycles($urandom_range(0, 2));
            end
            wait_drain();
        end

        // Reset mid-frame: outputs clear before the next edge
        drive_beat(0, 32'h11223344, 1'b0, 1'b0);
        drive_beat(0, 32'h55667788, 1'b0, 1'b0);
        chk("mid_busy", {63'b0, bz0}, 64'd1);
        rst_n = 1'b0;
        q0.delete();
        in_frame = 1'b0;
        #1;
        chk("arst_outs",  {30'b0, ov0, ol0, xo0}, 64'd0);
        chk("arst_ready", {63'b0, rdy0}, 64'd1);
        chk("arst_busy",  {63'b0, bz0},  64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle_cycles(4);
        chk("post_rst_quiet", {30'b0, ov0, ol0, xo0}, 64'd0);

        chk("queues_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
